// File: rtl/cmd_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// cmd_frame_arbiter_if
//
// Bundles the request, trigger and serializer handshakes of the command frame
// arbiter into one interface.
//
//   req_valid  [3:0]          lane frame-valid, one bit per requester lane
//   req_frame  [4*FRAME_W-1:0] lane i frame at bits [i*FRAME_W +: FRAME_W]
//   req_ready  [3:0]          one-hot lane accept strobe
//   trig_valid / trig_frame   high-priority trigger request and its frame
//   trig_ready                trigger accept strobe
//   out_valid / out_frame     registered frame offered to the serializer
//   out_src    [2:0]          0-3 lane, 4 trigger, 5 sync/filler
//   out_ready                 serializer takes out_frame this cycle
//
// Modports:
//   slave  - the arbiter: consumes requests, produces the serializer stream
//   master - the environment: requesters plus serializer
// -----------------------------------------------------------------------------
interface cmd_frame_arbiter_if #(
  parameter int FRAME_W = 16
);

  logic [3:0]           req_valid;
  logic [4*FRAME_W-1:0] req_frame;
  logic [3:0]           req_ready;

  logic                 trig_valid;
  logic [FRAME_W-1:0]   trig_frame;
  logic                 trig_ready;

  logic                 out_valid;
  logic [FRAME_W-1:0]   out_frame;
  logic                 out_ready;
  logic [2:0]           out_src;

  modport slave (
    input  req_valid, req_frame, trig_valid, trig_frame, out_ready,
    output req_ready, trig_ready, out_valid, out_frame, out_src
  );

  modport master (
    output req_valid, req_frame, trig_valid, trig_frame, out_ready,
    input  req_ready, trig_ready, out_valid, out_frame, out_src
  );

endinterface

// File: rtl/cmd_frame_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_frame_arbiter
//
// Merges four requester lanes and one high-priority trigger into a single
// registered frame stream for a serializer, inserting a sync word every
// SYNC_PERIOD accepted non-sync frames and (optionally) filler sync words
// when nothing is pending.
//
// Selection priority on a load cycle:
//   trigger  >  sync due  >  round-robin lanes  >  idle filler  >  nothing
// The trigger drops below the lanes once it has won TRIG_BURST grants in a
// row while some lane is waiting.
//
// Ports:
//   clk  - single clock
//   rst  - asynchronous, active-low reset
//   bus  - cmd_frame_arbiter_if.slave (request, trigger, serializer signals)
// -----------------------------------------------------------------------------
module cmd_frame_arbiter #(
  parameter int                 FRAME_W     = 16,
  parameter int                 SYNC_PERIOD = 32,
  parameter logic [FRAME_W-1:0] SYNC_WORD   = 16'h817E,
  parameter bit                 IDLE_FILL   = 1'b1,
  parameter int                 TRIG_BURST  = 4
) (
  input  logic                clk,
  input  logic                rst,
  cmd_frame_arbiter_if.slave  bus
);

  localparam int CNT_W   = $clog2(SYNC_PERIOD + 1);
  localparam int BURST_W = $clog2(TRIG_BURST + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(SYNC_PERIOD);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(TRIG_BURST);

  localparam logic [2:0] SRC_TRIG = 3'd4;
  localparam logic [2:0] SRC_SYNC = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [FRAME_W-1:0] out_frame_q;
  logic [2:0]         out_src_q;
  logic [1:0]         ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BURST_W-1:0] burst_q;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic load;

  assign accept = (state_q == SEND) & bus.out_ready;
  // A new source is chosen whenever the output register is empty or being
  // emptied this cycle; otherwise the held frame blocks all grants.
  assign load   = (state_q == IDLE) | accept;

  // ---------------------------------------------------------------------------
  // Sync counter
  // ---------------------------------------------------------------------------
  // cnt_seen includes the non-sync frame being accepted this cycle, so the
  // frame loaded alongside the SYNC_PERIOD-th acceptance is already the sync.
  // A sync accepted this cycle does not clear cnt_seen: the due decision for
  // the same cycle uses the count from before the clear.
  logic [CNT_W-1:0] cnt_seen;
  logic [CNT_W-1:0] cnt_d;
  logic             sync_due;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_seen = cnt_q;
    if (accept && (out_src_q != SRC_SYNC) && (cnt_q < CNT_MAX)) begin
      cnt_seen = cnt_q + 1'b1;
    end

    cnt_d = cnt_seen;
    if (accept && (out_src_q == SRC_SYNC)) begin
      cnt_d = '0;
    end
  end

  assign sync_due = (cnt_seen >= CNT_MAX);

  // ---------------------------------------------------------------------------
  // Round-robin lane search starting at ptr_q
  // ---------------------------------------------------------------------------
  logic               lane_hit;
  logic [1:0]         lane_sel;
  logic [1:0]         rr_idx;
  logic [FRAME_W-1:0] lane_frame;

  always_comb begin
    lane_hit   = 1'b0;
    lane_sel   = ptr_q;
    rr_idx     = ptr_q;
    lane_frame = '0;
    for (int k = 0; k < 4; k++) begin
      // 2-bit add wraps 3 -> 0 naturally.
      rr_idx = ptr_q + 2'(k);
      if (!lane_hit && bus.req_valid[rr_idx]) begin
        lane_hit   = 1'b1;
        lane_sel   = rr_idx;
        lane_frame = bus.req_frame[rr_idx*FRAME_W +: FRAME_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Source selection
  // ---------------------------------------------------------------------------
  logic               trig_ok;
  logic               sel_valid;
  logic [2:0]         sel_src;
  logic [FRAME_W-1:0] sel_frame;

  // The trigger is only demoted if there is actually a lane it could starve.
  assign trig_ok = bus.trig_valid & ~((burst_q >= BURST_MAX) & lane_hit);

  always_comb begin
    sel_valid = 1'b0;
    sel_src   = '0;
    sel_frame = '0;
    if (trig_ok) begin
      sel_valid = 1'b1;
      sel_src   = SRC_TRIG;
      sel_frame = bus.trig_frame;
    end else if (sync_due) begin
      sel_valid = 1'b1;
      sel_src   = SRC_SYNC;
      sel_frame = SYNC_WORD;
    end else if (lane_hit) begin
      sel_valid = 1'b1;
      sel_src   = {1'b0, lane_sel};
      sel_frame = lane_frame;
    end else if (IDLE_FILL) begin
      sel_valid = 1'b1;
      sel_src   = SRC_SYNC;
      sel_frame = SYNC_WORD;
    end
  end

  // ---------------------------------------------------------------------------
  // Accept strobes: combinational, only on load, forced low during reset
  // ---------------------------------------------------------------------------
  logic grant;

  assign grant          = rst & load & sel_valid;
  assign bus.req_ready  = (grant && !sel_src[2]) ? (4'b0001 << lane_sel) : 4'b0000;
  assign bus.trig_ready = grant & (sel_src == SRC_TRIG);

  // ---------------------------------------------------------------------------
  // FSM and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_frame_q <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      cnt_q <= cnt_d;
      if (load) begin
        if (sel_valid) begin
          state_q     <= SEND;
          out_frame_q <= sel_frame;
          out_src_q   <= sel_src;
          if (sel_src == SRC_TRIG) begin
            if (burst_q < BURST_MAX) begin
              burst_q <= burst_q + 1'b1;
            end
          end else begin
            burst_q <= '0;
          end
          // Only lane grants advance the round-robin pointer.
          if (!sel_src[2]) begin
            ptr_q <= lane_sel + 2'd1;
          end
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.out_frame = out_frame_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_cmd_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_arbiter
//
// Two arbiters side by side on identical stimulus:
//   dut0 - defaults (SYNC_PERIOD 32, IDLE_FILL 1, TRIG_BURST 4)
//   dut1 - SYNC_PERIOD 5, IDLE_FILL 0, TRIG_BURST 2
// Each is compared every cycle against a transaction-level reference model;
// directed scenarios add fixed expected sequences on top.
// -----------------------------------------------------------------------------
module tb_cmd_frame_arbiter;

  localparam int FW = 16;
  localparam logic [FW-1:0] SYNC = 16'h817E;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cmd_frame_arbiter_if #(.FRAME_W(FW)) bus0 ();
  cmd_frame_arbiter_if #(.FRAME_W(FW)) bus1 ();

  cmd_frame_arbiter #(.FRAME_W(FW)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  cmd_frame_arbiter #(
    .FRAME_W    (FW),
    .SYNC_PERIOD(5),
    .SYNC_WORD  (16'h817E),
    .IDLE_FILL  (1'b0),
    .TRIG_BURST (2)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: what the serializer should see, tracked per transaction
  // ---------------------------------------------------------------------------
  typedef struct {
    int          ptr;    // next lane to look at first
    int          cnt;    // accepted non-sync frames since last sync
    int          burst;  // trigger grants in a row
    bit          valid;  // a frame is on offer
    logic [15:0] frame;
    int          src;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_reset();
    model_t r;
    r.ptr = 0; r.cnt = 0; r.burst = 0; r.valid = 1'b0; r.frame = '0; r.src = 0;
    return r;
  endfunction

  function automatic void model_step(
    input  model_t      s,
    input  int          period,
    input  bit          fill,
    input  int          tburst,
    input  logic [3:0]  rv,
    input  logic [63:0] rf,
    input  bit          tv,
    input  logic [15:0] tf,
    input  bit          ordy,
    output model_t      ns,
    output logic [3:0]  rdy,
    output bit          trdy
  );
    bit accept, take_new, due, any;
    int seen, src;
    ns = s; rdy = 4'b0000; trdy = 1'b0;
    accept   = s.valid && ordy;
    take_new = !s.valid || accept;
    seen = s.cnt;
    if (accept && s.src != 5) seen = (s.cnt + 1 > period) ? period : s.cnt + 1;
    due = (seen >= period);
    if (accept) ns.cnt = (s.src == 5) ? 0 : seen;
    if (!take_new) return;
    any = (rv != 4'b0000);
    src = -1;
    if (tv && !(s.burst >= tburst && any)) begin
      src = 4;
    end else if (due) begin
      src = 5;
    end else if (any) begin
      for (int k = 0; k < 4; k++) begin
        if (src < 0 && rv[(s.ptr + k) % 4]) src = (s.ptr + k) % 4;
      end
    end else if (fill) begin
      src = 5;
    end
    if (src < 0) begin
      ns.valid = 1'b0;
      return;
    end
    ns.valid = 1'b1;
    ns.src   = src;
    if (src == 4) begin
      ns.frame = tf; trdy = 1'b1; ns.burst = s.burst + 1;
    end else if (src == 5) begin
      ns.frame = SYNC; ns.burst = 0;
    end else begin
      ns.frame = rf[src*16 +: 16]; rdy[src] = 1'b1;
      ns.ptr = (src + 1) % 4; ns.burst = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // dut0 outputs as seen in the most recent cycle, for directed checks
  logic [3:0]  obs_rr;
  logic        obs_tr, obs_v, obs1_v;
  logic [15:0] obs_f;
  logic [2:0]  obs_s;

  task automatic set_inputs(input logic [3:0] rv, input logic [63:0] rf, input bit tv,
                            input logic [15:0] tf, input bit ordy);
    bus0.req_valid = rv; bus0.req_frame = rf; bus0.trig_valid = tv;
    bus0.trig_frame = tf; bus0.out_ready = ordy;
    bus1.req_valid = rv; bus1.req_frame = rf; bus1.trig_valid = tv;
    bus1.trig_frame = tf; bus1.out_ready = ordy;
  endtask

  // Called at a falling edge: drive, let logic settle, compare, then step to
  // the next falling edge (the rising edge in between commits the cycle).
  task automatic drive_cycle(input logic [3:0] rv, input logic [63:0] rf, input bit tv,
                             input logic [15:0] tf, input bit ordy);
    model_t n0, n1;
    logic [3:0] r0, r1;
    bit t0, t1;
    set_inputs(rv, rf, tv, tf, ordy);
    #1;
    model_step(m0, 32, 1'b1, 4, rv, rf, tv, tf, ordy, n0, r0, t0);
    model_step(m1, 5, 1'b0, 2, rv, rf, tv, tf, ordy, n1, r1, t1);
    check("d0 out_valid", bus0.out_valid, m0.valid);
    if (m0.valid) begin
      check("d0 out_frame", bus0.out_frame, m0.frame);
      check("d0 out_src", bus0.out_src, m0.src);
    end
    check("d0 req_ready", bus0.req_ready, r0);
    check("d0 trig_ready", bus0.trig_ready, t0);
    check("d1 out_valid", bus1.out_valid, m1.valid);
    if (m1.valid) begin
      check("d1 out_frame", bus1.out_frame, m1.frame);
      check("d1 out_src", bus1.out_src, m1.src);
    end
    check("d1 req_ready", bus1.req_ready, r1);
    check("d1 trig_ready", bus1.trig_ready, t1);
    obs_rr = bus0.req_ready; obs_tr = bus0.trig_ready; obs_v = bus0.out_valid;
    obs_f = bus0.out_frame; obs_s = bus0.out_src; obs1_v = bus1.out_valid;
    m0 = n0;
    m1 = n1;
    @(negedge clk);
  endtask

  // Asserts reset with every request active, so the strobe gating is exercised.
  task automatic apply_reset();
    rst = 1'b0;
    set_inputs(4'hF, 64'h1111_2222_3333_4444, 1'b1, 16'h5555, 1'b1);
    #1;
    m0 = model_reset();
    m1 = model_reset();
    check("rst d0 out_valid", bus0.out_valid, 1'b0);
    check("rst d0 out_frame", bus0.out_frame, 16'h0000);
    check("rst d0 out_src", bus0.out_src, 3'd0);
    check("rst d0 req_ready", bus0.req_ready, 4'b0000);
    check("rst d0 trig_ready", bus0.trig_ready, 1'b0);
    check("rst d1 out_valid", bus1.out_valid, 1'b0);
    check("rst d1 req_ready", bus1.req_ready, 4'b0000);
    check("rst d1 trig_ready", bus1.trig_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] rf_all;
    int          trig_exp [10];
    int          accepted;
    int          budget;

    rf_all   = 64'hD003_D002_D001_D000;
    trig_exp = '{4, 4, 4, 4, 1, 4, 4, 4, 4, 1};

    @(negedge clk);
    apply_reset();

    // Round robin: all lanes valid, serializer always ready.
    drive_cycle(4'hF, rf_all, 1'b0, 16'h0, 1'b1);
    check("rr first grant", obs_rr, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'hF, rf_all, 1'b0, 16'h0, 1'b1);
      check("rr src", obs_s, i % 4);
      check("rr frame", obs_f, 16'hD000 + i % 4);
      check("rr ready", obs_rr, 4'b0001 << ((i + 1) % 4));
    end

    // Backpressure: lane 2 frame held for 5 stalled cycles.
    apply_reset();
    drive_cycle(4'b0100, 64'h0000_1234_0000_0000, 1'b0, 16'h0, 1'b0);
    check("bp grant", obs_rr, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b0100, 64'h0000_5678_0000_0000, 1'b0, 16'h0, 1'b0);
      check("bp hold frame", obs_f, 16'h1234);
      check("bp hold valid", obs_v, 1'b1);
      check("bp no req_ready", obs_rr, 4'b0000);
      check("bp no trig_ready", obs_tr, 1'b0);
    end
    drive_cycle(4'b0100, 64'h0000_5678_0000_0000, 1'b0, 16'h0, 1'b1);
    check("bp accept frame", obs_f, 16'h1234);
    check("bp accept grant", obs_rr, 4'b0100);
    drive_cycle(4'b0000, 64'h0, 1'b0, 16'h0, 1'b1);
    check("bp next frame", obs_f, 16'h5678);

    // Trigger burst against a waiting lane 1.
    apply_reset();
    drive_cycle(4'b0010, rf_all, 1'b1, 16'hABCD, 1'b1);
    check("tb first trig_ready", obs_tr, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(4'b0010, rf_all, 1'b1, 16'hABCD, 1'b1);
      check("tb src", obs_s, trig_exp[i]);
    end

    // Sync insertion: 33rd accepted frame is the sync word.
    apply_reset();
    accepted = 0;
    budget   = 0;
    while (accepted < 33 && budget < 200) begin
      drive_cycle(4'b0001, 64'h0000_0000_0000_0AA0, 1'b0, 16'h0, 1'b1);
      budget++;
      if (obs_v) begin
        accepted++;
        if (accepted == 32) check("sync 32nd src", obs_s, 3'd0);
        if (accepted == 33) begin
          check("sync 33rd src", obs_s, 3'd5);
          check("sync 33rd frame", obs_f, SYNC);
        end
      end
    end
    check("sync reached 33 frames", accepted, 33);
    // Next forced sync only after another full period of lane frames.
    for (int i = 0; i < 40; i++) drive_cycle(4'b0001, 64'h0AA0, 1'b0, 16'h0, 1'b1);

    // Idle fill: dut0 streams sync words, dut1 stays idle.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(4'b0000, 64'h0, 1'b0, 16'h0, 1'b1);
      check("fill d0 valid", obs_v, i > 0);
      if (i > 0) begin
        check("fill d0 frame", obs_f, SYNC);
        check("fill d0 src", obs_s, 3'd5);
      end
      check("fill d1 valid", obs1_v, 1'b0);
    end

    // Mid-operation reset while sending; grants restart at lane 0.
    apply_reset();
    for (int i = 0; i < 3; i++) drive_cycle(4'hF, rf_all, 1'b0, 16'h0, 1'b1);
    check("mid sending before reset", bus0.out_valid, 1'b1);
    apply_reset();
    drive_cycle(4'hF, rf_all, 1'b0, 16'h0, 1'b1);
    check("mid restart grant", obs_rr, 4'b0001);
    check("mid restart idle", obs_v, 1'b0);

    // Random traffic, light then heavy trigger load.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 2000; i++) begin
        logic [3:0]  rv;
        logic [63:0] rf;
        bit          tv, ordy;
        rv   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        rf   = {$urandom, $urandom};
        tv   = (phase == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) < 8);
        ordy = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 999) == 0) apply_reset();
        drive_cycle(rv, rf, tv, 16'($urandom), ordy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_frame_arbiter.md
CMD_FRAME_ARBITER -- requirements
Module: cmd_frame_arbiter

Interface
REQ-001 SHALL have parameter FRAME_W, default 16, command frame width in bits.
REQ-002 SHALL have parameter SYNC_PERIOD, default 32, number of accepted non-sync frames after which a sync frame is forced.
REQ-003 SHALL have parameter SYNC_WORD, default 16'h817E, sync/filler frame value.
REQ-004 SHALL have parameter IDLE_FILL, default 1, which when 1 emits SYNC_WORD whenever no request is pending.
REQ-005 SHALL have parameter TRIG_BURST, default 4, maximum consecutive trigger grants while any requester waits.
REQ-006 SHALL have port clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 4, one frame-valid bit per requester lane.
REQ-009 SHALL have port req_frame, input, 4*FRAME_W, the frame for lane i at bits [i*FRAME_W +: FRAME_W].
REQ-010 SHALL have port req_ready, output, 4, a one-hot accept strobe per lane.
REQ-011 SHALL have port trig_valid, input, 1, a high-priority trigger frame request.
REQ-012 SHALL have port trig_frame, input, FRAME_W, the trigger frame.
REQ-013 SHALL have port trig_ready, output, 1, the trigger accept strobe.
REQ-014 SHALL have port out_valid, output, 1, which is high while out_frame holds a frame for the serializer.
REQ-015 SHALL have port out_frame, output, FRAME_W, the registered frame to the serializer.
REQ-016 SHALL have port out_ready, input, 1, which signals that the serializer accepts out_frame this cycle.
REQ-017 SHALL have port out_src, output, 3, frame source: 0-3 for lanes, 4 for trigger, 5 for sync.

Function
REQ-018 SHALL implement states IDLE (out_valid=0) and SEND (out_valid=1).
REQ-019 SHALL define load = (state==IDLE) | (out_valid & out_ready), and SHALL select a new source only on load cycles.
REQ-020 SHALL apply selection priority on load: trigger, then sync_due, then round-robin lanes, then idle filler (IDLE_FILL=1), then none.
REQ-021 SHALL demote the trigger below the lanes when the TRIG_BURST consecutive trigger grants limit has been reached and any req_valid is high; the burst count SHALL clear on any non-trigger grant.
REQ-022 SHALL drive req_ready[i] and trig_ready combinationally, high only on a load cycle for the granted source; at most one of the five SHALL be high.
REQ-023 SHALL register the granted frame into out_frame and out_src on the load cycle, giving 1-cycle latency from the accept strobe to out_valid.
REQ-024 SHALL hold out_frame and out_src stable while out_valid=1 and out_ready=0.
REQ-025 SHALL transition SEND->IDLE when load occurs with no source selected, and IDLE->SEND when a source is selected.
REQ-026 SHALL keep round-robin pointer ptr (2 bits): the search starts at ptr, and on a lane-i grant ptr becomes (i+1) mod 4, wrapping 3->0; trigger and sync grants SHALL NOT move ptr.
REQ-027 SHALL keep sync counter cnt: it increments on each out_valid&out_ready with out_src!=5, saturates at SYNC_PERIOD, and clears to 0 on acceptance of a sync frame; sync_due = (cnt >= SYNC_PERIOD).
REQ-028 SHALL, on a simultaneous sync acceptance and load, use the pre-clear cnt value for that cycle's sync_due decision.
REQ-029 SHALL NOT assert any ready output when out_valid=1 and out_ready=0.

Reset
REQ-030 SHALL, while rst=0, immediately force state=IDLE, out_valid=0, out_frame=0, out_src=0, ptr=0, cnt=0, and burst count=0.
REQ-031 SHALL gate req_ready and trig_ready to 0 while rst=0, and SHALL drop any frame in flight at reset.
REQ-032 SHALL evaluate the first load on the first clk edge after rst deasserts.

Verification
REQ-033 SHALL pass a round-robin test: all 4 lanes valid, out_ready=1 -> out_src sequence 0,1,2,3,0 and each req_ready pulses once per 4 cycles.
REQ-034 SHALL pass a backpressure test: lane 2 frame 16'h1234 with out_ready=0 for 5 cycles -> out_frame=16'h1234 stable and no ready strobes, then one accept when out_ready=1.
REQ-035 SHALL pass a trigger burst test: trig_valid and lane 1 valid continuously -> out_src 4,4,4,4,1,4,4,4,4,1.
REQ-036 SHALL pass a sync insertion test: SYNC_PERIOD=32 with lane 0 continuously valid -> the 33rd accepted frame is 16'h817E with out_src=5, then cnt=0.
REQ-037 SHALL pass an idle fill test: no requests, IDLE_FILL=1 -> continuous 16'h817E frames; with IDLE_FILL=0 -> out_valid=0.
REQ-038 SHALL pass a mid-operation reset test: rst asserted while in SEND -> out_valid=0 in the same cycle, and after release the grant starts at lane 0.
